// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int INSN_BYTES = 4;
   localparam int IFU_AW     = 32;
   localparam int IFU_DW     = 32;

   typedef struct packed {
      logic [IFU_AW-1:0] pc;
      logic [IFU_DW-1:0] ir;
   } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf.sv
// Instruction buffer: synchronous FIFO of {pc, ir} entries with a priority flush.
module ifu_ibuf
   import ifu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = ibuf_entry_t
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  entry_t                     din,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output entry_t                     head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & ~empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: credit-limited sequential fetch feeding an in-order instruction buffer.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int             AW       = 32,
   parameter int             DW       = 32,
   parameter int             DEPTH    = 4,
   parameter int             MAX_OUTS = 2,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          ifetch_req_vld,
   input  logic          ifetch_req_rdy,
   output logic [AW-1:0] ifetch_req_pc,
   input  logic          ifetch_rsp_vld,
   output logic          ifetch_rsp_rdy,
   input  logic [DW-1:0] ifetch_rsp_ir,
   output logic          iexec_req_vld,
   input  logic          iexec_req_rdy,
   output logic [AW-1:0] iexec_req_pc,
   output logic [DW-1:0] iexec_req_ir,
   input  logic          redir_vld,
   input  logic [AW-1:0] redir_pc,
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_drop_cnt
);

   localparam int IW = $clog2(MAX_OUTS+1);
   localparam int CW = $clog2(DEPTH+1);
   localparam int QW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] ir;
   } entry_t;

   logic          run;
   logic [AW-1:0] fetch_pc;
   logic [IW-1:0] inflight;
   logic [IW-1:0] drop_cnt;
   logic [AW-1:0] pcq [MAX_OUTS];
   logic [QW-1:0] pcq_wr;
   logic [QW-1:0] pcq_rd;
   logic          credit;
   logic          req_hsk;
   logic          rsp_hsk;
   logic          rsp_keep;
   logic          exec_hsk;
   logic [CW-1:0] count;
   logic          ibuf_full;
   logic          ibuf_empty;
   entry_t        ibuf_din;
   entry_t        ibuf_head;

   function automatic logic [QW-1:0] pcq_next(input logic [QW-1:0] p);
      return (int'(p) == MAX_OUTS-1) ? '0 : p + 1'b1;
   endfunction

   // Buffer space is reserved at request time, so responses never need back-pressure.
   assign credit         = (int'(inflight) < MAX_OUTS) && (int'(inflight) + int'(count) < DEPTH);
   assign ifetch_req_vld = run & ~redir_vld & credit;
   assign ifetch_req_pc  = fetch_pc;
   assign ifetch_rsp_rdy = run;

   assign req_hsk  = ifetch_req_vld & ifetch_req_rdy;
   assign rsp_hsk  = ifetch_rsp_vld & ifetch_rsp_rdy;
   assign rsp_keep = rsp_hsk & ~redir_vld & (drop_cnt == '0);

   assign iexec_req_vld = ~ibuf_empty & ~redir_vld;
   assign exec_hsk      = iexec_req_vld & iexec_req_rdy;
   assign iexec_req_pc  = ibuf_head.pc;
   assign iexec_req_ir  = ibuf_head.ir;

   assign ibuf_din.pc = pcq[pcq_rd];
   assign ibuf_din.ir = ifetch_rsp_ir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         pcq_wr   <= '0;
         pcq_rd   <= '0;
      end else begin
         run <= 1'b1;
         if (req_hsk) pcq_wr <= pcq_next(pcq_wr);
         if (rsp_hsk) pcq_rd <= pcq_next(pcq_rd);
         case ({req_hsk, rsp_hsk})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         // inflight already counts responses still owed to earlier redirects,
         // so every outstanding fetch becomes stale here.
         if (redir_vld) begin
            fetch_pc <= redir_pc;
            drop_cnt <= inflight - IW'(rsp_hsk);
         end else begin
            if (req_hsk) fetch_pc <= fetch_pc + AW'(INSN_BYTES);
            if (rsp_hsk && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_hsk) pcq[pcq_wr] <= fetch_pc;
   end

   ifu_ibuf #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_keep),
      .pop   (exec_hsk),
      .flush (redir_vld),
      .din   (ibuf_din),
      .full  (ibuf_full),
      .empty (ibuf_empty),
      .count (count),
      .head  (ibuf_head)
   );

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && ibuf_full));

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (req_hsk)              fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (rsp_hsk && !rsp_keep) drop_cnt_q  <= drop_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_drop_cnt  = drop_cnt_q;
`else
   assign perf_fetch_cnt = '0;
   assign perf_drop_cnt  = '0;
`endif

endmodule
